// File: rtl/stopwatch_fnd_ctrl.sv
// stopwatch_fnd_ctrl: 4-digit common-anode FND scanner for the stopwatch.
// Shows SS.mm (mode 0) or HH.MM (mode 1) with a 1 Hz blinking centre point.
// Every output is registered. Each digit enable and its segment pattern are
// loaded on the same scan edge, so no digit ever shows another digit's segments.
module stopwatch_fnd_ctrl #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned SCAN_HZ  = 1_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_mode,
   input  logic [6:0] i_msec,
   input  logic [5:0] i_sec,
   input  logic [5:0] i_min,
   input  logic [5:0] i_hour,
   output logic [3:0] o_fnd_com,
   output logic [7:0] o_fnd_data
);

   localparam int unsigned SCAN_DIV = CLK_FREQ / SCAN_HZ;
   localparam int unsigned CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DIG_W    = 4;
   localparam int unsigned SEG_W    = 7;

   // Active-low {g,f,e,d,c,b,a} patterns
   localparam logic [SEG_W-1:0] SEG_0    = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1    = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2    = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3    = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4    = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5    = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6    = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7    = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8    = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9    = 7'h10;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'h3F;

   logic [CNT_W-1:0] r_scan_cnt;
   logic [1:0]       r_dig_idx;
   logic [3:0]       r_fnd_com;
   logic [7:0]       r_fnd_data;

   logic             w_scan_tick;
   logic [DIG_W-1:0] w_msec_ones;
   logic [DIG_W-1:0] w_msec_tens;
   logic [DIG_W-1:0] w_sec_ones;
   logic [DIG_W-1:0] w_sec_tens;
   logic [DIG_W-1:0] w_min_ones;
   logic [DIG_W-1:0] w_min_tens;
   logic [DIG_W-1:0] w_hour_ones;
   logic [DIG_W-1:0] w_hour_tens;
   logic [DIG_W-1:0] w_digit;
   logic [SEG_W-1:0] w_seg;
   logic             w_dp_n;
   logic [3:0]       w_com;

   // Tick marks the last cycle of each digit slot
   assign w_scan_tick = (r_scan_cnt == CNT_W'(SCAN_DIV - 1));

   // Decimal split at full input width; tens may exceed 9 for out-of-range counts
   assign w_msec_ones = DIG_W'(i_msec % 7'd10);
   assign w_msec_tens = DIG_W'(i_msec / 7'd10);
   assign w_sec_ones  = DIG_W'(i_sec  % 6'd10);
   assign w_sec_tens  = DIG_W'(i_sec  / 6'd10);
   assign w_min_ones  = DIG_W'(i_min  % 6'd10);
   assign w_min_tens  = DIG_W'(i_min  / 6'd10);
   assign w_hour_ones = DIG_W'(i_hour % 6'd10);
   assign w_hour_tens = DIG_W'(i_hour / 6'd10);

   // Scan counter: free-running 0..SCAN_DIV-1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan_cnt <= '0;
      end else if (w_scan_tick) begin
         r_scan_cnt <= '0;
      end else begin
         r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
   end

   // Digit index advances after each load; wraps naturally 3 -> 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dig_idx <= 2'd0;
      end else if (w_scan_tick) begin
         r_dig_idx <= r_dig_idx + 2'd1;
      end
   end

   // Select the BCD value for the current digit from the active view
   always_comb begin
      w_digit = '0;
      unique case (r_dig_idx)
         2'd0:    w_digit = i_mode ? w_min_ones  : w_msec_ones;
         2'd1:    w_digit = i_mode ? w_min_tens  : w_msec_tens;
         2'd2:    w_digit = i_mode ? w_hour_ones : w_sec_ones;
         default: w_digit = i_mode ? w_hour_tens : w_sec_tens;
      endcase
   end

   // Seven-segment decode; anything above 9 shows a dash
   always_comb begin
      w_seg = SEG_DASH;
      unique case (w_digit)
         4'd0:    w_seg = SEG_0;
         4'd1:    w_seg = SEG_1;
         4'd2:    w_seg = SEG_2;
         4'd3:    w_seg = SEG_3;
         4'd4:    w_seg = SEG_4;
         4'd5:    w_seg = SEG_5;
         4'd6:    w_seg = SEG_6;
         4'd7:    w_seg = SEG_7;
         4'd8:    w_seg = SEG_8;
         4'd9:    w_seg = SEG_9;
         default: w_seg = SEG_DASH;
      endcase
   end

   // Centre point lit during the first half of every second
   assign w_dp_n = ~((r_dig_idx == 2'd2) && (i_msec < 7'd50));

   // One-cold digit enable for the current index
   assign w_com = ~(4'b0001 << r_dig_idx);

   // Output registers: enable and segments loaded together on the scan tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fnd_com  <= 4'b1111;
         r_fnd_data <= 8'hFF;
      end else if (w_scan_tick) begin
         r_fnd_com  <= w_com;
         r_fnd_data <= {w_dp_n, w_seg};
      end
   end

   assign o_fnd_com  = r_fnd_com;
   assign o_fnd_data = r_fnd_data;

endmodule
